// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serializer.
// Bytes are accepted on a valid/ready port and sent LSB-first, back-to-back when queued.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line high, waiting for a queued byte
// S_START | start bit (0) for CLKS_PER_BIT clocks
// S_DATA  | data bit shift_q[bit_q] for CLKS_PER_BIT clocks, LSB first
// S_STOP  | stop bit (1); done pulse on last cycle, chain next byte if queued
module uart_tx #(
    parameter int FPGA_clk_freq = 50000000,
    parameter int baudrate      = 115200,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_TX_DV,
    input  logic [7:0]                    i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Active,
    output logic                          o_TX_Done
);

    localparam int CLKS_PER_BIT = FPGA_clk_freq / baudrate;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CW           = PTR_W + 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DONE_AT  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               serial_q, serial_d;
    logic               active_q, active_d;
    logic               done_q, done_d;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ready_q, ready_d;

    logic               push;
    logic               pop;
    logic               fifo_nonempty;
    logic               bit_end;
    logic [7:0]         head;

    // Ready is registered, so a write while full is dropped even if a pop frees a slot that edge.
    always_comb begin
        push          = i_TX_DV & ready_q;
        fifo_nonempty = (count_q != '0);
        head          = mem[rd_ptr_q];
        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d       = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d < DEPTH_C);
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        bit_end = (baud_q == BIT_LAST);
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                done_d = (baud_q == DONE_AT);
                if (bit_end) begin
                    baud_d = '0;
                    bit_d  = '0;
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Line outputs are derived from the next state so they register in step with it.
    always_comb begin
        serial_d = 1'b1;
        active_d = (state_d != S_IDLE);
        case (state_d)
            S_START: serial_d = 1'b0;
            S_DATA:  serial_d = shift_d[bit_d];
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr_q] <= i_TX_Byte;
        end
    end

    assign o_TX_Ready   = ready_q;
    assign o_FIFO_Count = count_q;
    assign o_TX_Serial  = serial_q;
    assign o_TX_Active  = active_q;
    assign o_TX_Done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a cycle-count reference model predicts queue, line and pulses,
// and a line decoder recovers transmitted bytes and pops them against the expected queue.
module tb_uart_tx;

    localparam int CLK_F = 1700000;
    localparam int BAUD  = 100000;
    localparam int C     = CLK_F / BAUD;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       o_TX_Ready;
    logic [$clog2(DEPTH):0] o_FIFO_Count;
    logic       o_TX_Serial;
    logic       o_TX_Active;
    logic       o_TX_Done;

    uart_tx #(
        .FPGA_clk_freq(CLK_F),
        .baudrate     (BAUD),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_TX_DV     (dv),
        .i_TX_Byte   (din),
        .o_TX_Ready  (o_TX_Ready),
        .o_FIFO_Count(o_FIFO_Count),
        .o_TX_Serial (o_TX_Serial),
        .o_TX_Active (o_TX_Active),
        .o_TX_Done   (o_TX_Done)
    );

    always #5 clk = ~clk;

    int     mq[$];
    int     exp_q[$];
    bit     busy = 1'b0;
    longint cyc = 0;
    longint fs = 0;
    int     fb = 0;
    int     rst_epoch = 0;
    bit     chk_en = 1'b0;
    int     checks = 0;
    int     errors = 0;
    int     rx_count = 0;
    int     exp_frames = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a byte leaves the queue when the line is free, a frame lasts FRAME edges.
    initial begin : model
        int cnt_before;
        bit acc;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                if (busy && (cyc - 1 - fs) < longint'(9 * C + C / 2)) begin
                    void'(exp_q.pop_back());
                    exp_frames--;
                end
                rst_epoch++;
                mq.delete();
                busy = 1'b0;
            end else begin
                cnt_before = mq.size();
                acc = dv && (cnt_before < DEPTH);
                if (busy && cyc == fs + FRAME) busy = 1'b0;
                if (!busy && cnt_before > 0) begin
                    fb = mq.pop_front();
                    busy = 1'b1;
                    fs = cyc;
                    exp_q.push_back(fb);
                    exp_frames++;
                end
                if (acc) mq.push_back(int'(din));
            end
        end
    end

    initial begin : cycle_checker
        int k;
        int exp_ser;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_ser = 1;
                if (busy) begin
                    k = int'((cyc - fs) / C);
                    if (k == 0) exp_ser = 0;
                    else if (k <= 8) exp_ser = (fb >> (k - 1)) & 1;
                end
                check("fifo_count", longint'(o_FIFO_Count), mq.size());
                check("tx_ready", longint'(o_TX_Ready), (mq.size() < DEPTH) ? 1 : 0);
                check("tx_active", longint'(o_TX_Active), busy ? 1 : 0);
                check("tx_serial", longint'(o_TX_Serial), exp_ser);
                check("tx_done", longint'(o_TX_Done), (busy && cyc == fs + FRAME - 1) ? 1 : 0);
            end
        end
    end

    initial begin : rx_monitor
        int ep;
        int d;
        logic st;
        logic sp;
        forever begin
            @(negedge clk);
            if (chk_en && o_TX_Serial === 1'b0) begin
                ep = rst_epoch;
                d = 0;
                repeat (C / 2) @(negedge clk);
                st = o_TX_Serial;
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    if (o_TX_Serial) d |= (1 << i);
                end
                repeat (C) @(negedge clk);
                sp = o_TX_Serial;
                if (ep == rst_epoch) begin
                    rx_count++;
                    check("rx_framing", longint'({st, sp}), 1);
                    if (exp_q.size() == 0) check("rx_unexpected_byte", d, -1);
                    else check("rx_byte", d, exp_q.pop_front());
                end
            end
        end
    end

    task automatic write_byte(input int b);
        dv  = 1'b1;
        din = 8'(b);
        @(negedge clk);
        dv  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || mq.size() != 0) && n < 20 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", (n < 20 * FRAME) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_cyc(input longint target);
        int n = 0;
        while (cyc < target && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("wait_cycle_reached", cyc, target);
    endtask

    initial begin : stimulus
        int vals[4];
        int len;
        vals = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_ready", longint'(o_TX_Ready), 1);
        check("reset_serial", longint'(o_TX_Serial), 1);

        write_byte(8'h37);
        wait_idle();

        for (int i = 0; i < 4; i++) begin
            dv = 1'b1;
            din = 8'(vals[i]);
            @(negedge clk);
        end
        dv = 1'b0;
        wait_idle();

        for (int b = 1; b <= 6; b++) begin
            dv = 1'b1;
            din = 8'(b);
            @(negedge clk);
        end
        dv = 1'b0;
        check("overflow_count", longint'(o_FIFO_Count), 4);
        check("overflow_ready", longint'(o_TX_Ready), 0);
        wait_idle();

        write_byte(8'h11);
        write_byte(8'h22);
        wait_cyc(fs + FRAME - 1);
        write_byte(8'h33);
        check("pushpop_count", longint'(o_FIFO_Count), 1);
        wait_idle();

        write_byte(8'hC3);
        write_byte(8'h44);
        write_byte(8'h55);
        wait_cyc(fs + 4 * C + C / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_serial", longint'(o_TX_Serial), 1);
        check("rst_active", longint'(o_TX_Active), 0);
        check("rst_count", longint'(o_FIFO_Count), 0);
        check("rst_ready", longint'(o_TX_Ready), 1);
        repeat (3 * FRAME) @(negedge clk);
        write_byte(8'h37);
        wait_idle();

        write_byte(8'h81);
        for (int i = 0; i < FRAME; i++) begin
            din = 8'($urandom);
            @(negedge clk);
        end
        wait_idle();

        repeat (50) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                dv = 1'($urandom_range(0, 1));
                din = 8'($urandom);
                @(negedge clk);
            end
            dv = 1'b0;
            repeat ($urandom_range(0, 12 * C)) @(negedge clk);
        end
        wait_idle();
        repeat (2 * C) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        check("frames_received", rx_count, exp_frames);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: the transmit end of the 8N1 link whose receive end is `UART_Rx`, running at the same FPGA clock and baud rate. It accepts bytes from fabric logic through a valid/ready write port and buffers them in a small FIFO. Each byte is serialized LSB-first as start bit, 8 data bits and stop bit on `o_TX_Serial`. The block sits between smartwatch application logic and the TX pin, and is looped back to `UART_Rx` in simulation.

## Interface
- `FPGA_clk_freq`, default 50000000: clock frequency in Hz.
- `baudrate`, default 115200: line rate in bits/s. `CLKS_PER_BIT = FPGA_clk_freq / baudrate` (integer division; 434 at the defaults). Must be ≥ 2.
- `FIFO_DEPTH`, default 4: byte buffer depth. Must be a power of 2 and ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `i_TX_DV`  in  1  write strobe; a byte is accepted on an edge where `i_TX_DV` and `o_TX_Ready` are both 1.
- `i_TX_Byte`  in  8  byte to send; sampled together with `i_TX_DV`.
- `o_TX_Ready`  out  1  FIFO not full (`o_FIFO_Count < FIFO_DEPTH`), registered.
- `o_FIFO_Count`  out  $clog2(FIFO_DEPTH)+1  number of bytes queued, not counting the byte on the line.
- `o_TX_Serial`  out  1  serial line; idles high.
- `o_TX_Active`  out  1  high while a frame is being driven (START, DATA and STOP states).
- `o_TX_Done`  out  1  one-cycle pulse on the last cycle of each stop bit.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **IDLE**: `o_TX_Serial`=1 and `o_TX_Active`=0. If the FIFO is non-empty, pop the head into the shift register and go to START.
- **START**: drive 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- **DATA**: drive `shift[index]` for `CLKS_PER_BIT` cycles. Bit index runs 0..7, LSB first. After bit 7, go to STOP.
- **STOP**: drive 1 for `CLKS_PER_BIT` cycles.
  - On the final cycle, assert `o_TX_Done`.
  - If the FIFO is non-empty on that edge, pop the next byte and go directly to START. Frames are then back-to-back with no idle gap.
  - Otherwise go to IDLE.
- Baud counter: width `$clog2(CLKS_PER_BIT)`, counts 0..`CLKS_PER_BIT`-1 and clears on every state or bit change. Every bit lasts exactly `CLKS_PER_BIT` clocks, and a full frame is exactly `10*CLKS_PER_BIT` clocks.
- FIFO: circular buffer with wrap-around read and write pointers plus an explicit count.
  - Push and pop on the same edge: count unchanged, both pointers advance.
  - Write while count == `FIFO_DEPTH`: dropped, with no state change. This holds even if a pop happens on the same edge, because ready is registered.
  - Pop only occurs when count > 0.
- The shift register is loaded only on a pop. Changes to `i_TX_Byte` never affect a frame already in progress.
- **Reset** (any time, including mid-frame):
  - State IDLE, FIFO flushed, pointers 0, `o_FIFO_Count`=0, `o_TX_Ready`=1.
  - `o_TX_Serial`=1, `o_TX_Active`=0, `o_TX_Done`=0.
  - An aborted frame is truncated. The line is high from the first edge after `rst` is sampled high. While `rst` is asserted, writes are ignored.

## Timing
- All outputs are registered; none has a combinational path from the inputs.
- Write to an empty, idle block at edge N:
  - `o_FIFO_Count`=1 after N.
  - Pop at N+1: `o_TX_Serial` falls and `o_TX_Active` rises after N+1, and count returns to 0.
- Latency from accepted write to the start-bit falling edge is 1 clock.
- Start-bit falling edge at edge S:
  - data bit i occupies edges S+(i+1)·`CLKS_PER_BIT` through S+(i+2)·`CLKS_PER_BIT`−1;
  - the stop bit begins at S+9·`CLKS_PER_BIT`;
  - `o_TX_Done` is high for the single cycle ending at S+10·`CLKS_PER_BIT`.
- The next start bit (back-to-back) or the return to IDLE occurs at S+10·`CLKS_PER_BIT`.
- `o_TX_Ready` deasserts on the edge where count reaches `FIFO_DEPTH`. It reasserts on the edge after the pop that frees a slot.

## Test plan
- **Single byte**: write 0x37 while idle, with `UART_Rx` looped back.
  - `UART_Rx` reports byte 0x37 with one DV pulse.
  - Line sequence 0,1,1,1,0,1,1,0,0,1, each bit held 434 clocks (8680 ns).
  - One `o_TX_Done` pulse, 4340 clocks after the start edge.
- **Back-to-back**: write 0x00, 0xFF, 0xA5, 0x5A on 4 consecutive cycles.
  - Four contiguous frames with no idle cycle between stop and start.
  - Rx receives the same four bytes in order; four `o_TX_Done` pulses spaced 4340 clocks apart.
- **Overflow**: hold `i_TX_DV` for 6 consecutive cycles with bytes 0x01..0x06.
  - 0x01 is popped immediately and 0x02..0x05 fill the FIFO.
  - `o_TX_Ready`=0 and `o_FIFO_Count`=4; 0x06 is dropped.
  - Exactly 0x01..0x05 are received.
- **Simultaneous push/pop**: with count=1 and a write on the stop-bit final edge, count stays 1 and the transmit order is preserved.
- **Reset mid-frame**: assert `rst` for 1 cycle during data bit 3 of 0xC3 with 2 bytes queued.
  - Next cycle: `o_TX_Serial`=1, `o_TX_Active`=0, count 0, `o_TX_Ready`=1.
  - No `o_TX_Done` and no further frames.
  - A following write of 0x37 transmits correctly.
- **Data stability**: change `i_TX_Byte` every cycle with `i_TX_DV`=0 during a 0x81 frame; the serialized bits still match 0x81.
